// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - VGA timing presets and counter-width helper
package vga_pkg;

    // 640x480 @ 60 Hz from a 50 MHz board clock (25 MHz pixel rate)
    localparam int VGA640_CLK_DIV      = 2;
    localparam int VGA640_H_RES        = 640;
    localparam int VGA640_H_SYNC_START = 656;
    localparam int VGA640_H_SYNC_END   = 752;
    localparam int VGA640_H_TOTAL      = 800;
    localparam int VGA640_V_RES        = 480;
    localparam int VGA640_V_SYNC_START = 490;
    localparam int VGA640_V_SYNC_END   = 492;
    localparam int VGA640_V_TOTAL      = 525;
    localparam bit VGA640_H_POL        = 1'b0;
    localparam bit VGA640_V_POL        = 1'b0;

    // 800x600 @ 72 Hz, pixel rate equal to the 50 MHz board clock
    localparam int VGA800_CLK_DIV      = 1;
    localparam int VGA800_H_RES        = 800;
    localparam int VGA800_H_SYNC_START = 856;
    localparam int VGA800_H_SYNC_END   = 976;
    localparam int VGA800_H_TOTAL      = 1040;
    localparam int VGA800_V_RES        = 600;
    localparam int VGA800_V_SYNC_START = 637;
    localparam int VGA800_V_SYNC_END   = 643;
    localparam int VGA800_V_TOTAL      = 666;
    localparam bit VGA800_H_POL        = 1'b1;
    localparam bit VGA800_V_POL        = 1'b1;

    // Smallest counter width able to hold 0..total-1
    function automatic int cnt_w_min(input int total);
        return (total <= 2) ? 1 : $clog2(total);
    endfunction

    localparam int VGA640_CNT_W_MIN = cnt_w_min(VGA640_H_TOTAL);
    localparam int VGA800_CNT_W_MIN = cnt_w_min(VGA800_H_TOTAL);

endpackage

// File: rtl/vga_axis_cnt.sv
// rtl/vga_axis_cnt.sv - one raster axis counter with sync/active decode of its next state
module vga_axis_cnt
    import vga_pkg::*;
#(
    parameter int RES        = 640,
    parameter int SYNC_START = 656,
    parameter int SYNC_END   = 752,
    parameter int TOTAL      = 800,
    parameter bit POL        = 1'b0,
    parameter int CNT_W      = 12
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_wrap,
    output logic             o_sync,
    output logic             o_active
);

    if (!(RES < SYNC_START && SYNC_START < SYNC_END && SYNC_END <= TOTAL)) begin : g_bad_order
        $error("vga_axis_cnt: need RES < SYNC_START < SYNC_END <= TOTAL");
    end
    if (CNT_W < cnt_w_min(TOTAL)) begin : g_bad_width
        $error("vga_axis_cnt: CNT_W too narrow for TOTAL");
    end

    // The last count sits at TOTAL-1, so the first increment after reset lands on 0
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

    // Decodes compare one bit wider so a SYNC_END equal to 2**CNT_W still works
    localparam logic [CNT_W:0] RES_W   = (CNT_W+1)'(RES);
    localparam logic [CNT_W:0] SSTRT_W = (CNT_W+1)'(SYNC_START);
    localparam logic [CNT_W:0] SEND_W  = (CNT_W+1)'(SYNC_END);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W:0]   cnt_ext;

    assign o_wrap = i_inc && (cnt_q == LAST);

    // Next count: hold, step, or wrap back to the first pixel/line
    always_comb begin
        cnt_d = cnt_q;
        if (i_inc) begin
            cnt_d = o_wrap ? '0 : cnt_q + 1'b1;
        end
    end

    // Count register; reset parks it on the final position
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= LAST;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Decode from the next-state count so the parent can register with no added latency
    assign cnt_ext  = {1'b0, cnt_d};
    assign o_cnt    = cnt_d;
    assign o_active = cnt_ext < RES_W;
    assign o_sync   = (cnt_ext >= SSTRT_W && cnt_ext < SEND_W) ? POL : ~POL;

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator with pixel clock-enable
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV      = VGA640_CLK_DIV,
    parameter int H_RES        = VGA640_H_RES,
    parameter int H_SYNC_START = VGA640_H_SYNC_START,
    parameter int H_SYNC_END   = VGA640_H_SYNC_END,
    parameter int H_TOTAL      = VGA640_H_TOTAL,
    parameter int V_RES        = VGA640_V_RES,
    parameter int V_SYNC_START = VGA640_V_SYNC_START,
    parameter int V_SYNC_END   = VGA640_V_SYNC_END,
    parameter int V_TOTAL      = VGA640_V_TOTAL,
    parameter bit H_POL        = VGA640_H_POL,
    parameter bit V_POL        = VGA640_V_POL,
    parameter int CNT_W        = 12
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    output logic             o_pix_ce,
    output logic             o_hsync,
    output logic             o_vsync,
    output logic             o_de,
    output logic [CNT_W-1:0] o_x,
    output logic [CNT_W-1:0] o_y,
    output logic             o_line_start,
    output logic             o_frame_start
);

    if (CLK_DIV < 1) begin : g_bad_div
        $error("vga_timing_gen: CLK_DIV must be at least 1");
    end

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0]    presc_q;
    logic [PW-1:0]    presc_d;
    logic             presc_wrap;
    logic             pix_inc;

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             h_wrap;
    logic             v_wrap;
    logic             h_sync;
    logic             v_sync;
    logic             h_active;
    logic             v_active;

    logic             pix_ce_q;
    logic             hsync_q;
    logic             vsync_q;
    logic             de_q;
    logic [CNT_W-1:0] x_q;
    logic [CNT_W-1:0] y_q;
    logic             line_start_q;
    logic             frame_start_q;

    // With CLK_DIV=1 the prescaler is pinned at 0 and wraps on every enabled cycle
    assign presc_wrap = (presc_q == PRESC_LAST);
    assign pix_inc    = i_en && presc_wrap;

    // Prescaler next state: advances only while enabled
    always_comb begin
        presc_d = presc_q;
        if (i_en) begin
            presc_d = presc_wrap ? '0 : presc_q + 1'b1;
        end
    end

    // Prescaler register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    vga_axis_cnt #(
        .RES        (H_RES),
        .SYNC_START (H_SYNC_START),
        .SYNC_END   (H_SYNC_END),
        .TOTAL      (H_TOTAL),
        .POL        (H_POL),
        .CNT_W      (CNT_W)
    ) u_h_cnt (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_inc    (pix_inc),
        .o_cnt    (h_cnt),
        .o_wrap   (h_wrap),
        .o_sync   (h_sync),
        .o_active (h_active)
    );

    vga_axis_cnt #(
        .RES        (V_RES),
        .SYNC_START (V_SYNC_START),
        .SYNC_END   (V_SYNC_END),
        .TOTAL      (V_TOTAL),
        .POL        (V_POL),
        .CNT_W      (CNT_W)
    ) u_v_cnt (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_inc    (h_wrap),
        .o_cnt    (v_cnt),
        .o_wrap   (v_wrap),
        .o_sync   (v_sync),
        .o_active (v_active)
    );

    // Output registers: strobes pulse on the advancing edge, levels load only when the raster moves
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pix_ce_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            hsync_q       <= ~H_POL;
            vsync_q       <= ~V_POL;
            de_q          <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
        end else begin
            pix_ce_q      <= pix_inc;
            line_start_q  <= h_wrap;
            frame_start_q <= h_wrap && v_wrap;
            if (pix_inc) begin
                hsync_q <= h_sync;
                vsync_q <= v_sync;
                de_q    <= h_active && v_active;
                x_q     <= h_cnt;
                y_q     <= v_cnt;
            end
        end
    end

    assign o_pix_ce      = pix_ce_q;
    assign o_hsync       = hsync_q;
    assign o_vsync       = vsync_q;
    assign o_de          = de_q;
    assign o_x           = x_q;
    assign o_y           = y_q;
    assign o_line_start  = line_start_q;
    assign o_frame_start = frame_start_q;

endmodule
